// File: rtl/card_dealer_pkg.sv
// ---------------------------------------------------------------------------
// card_dealer_pkg
// Constants and state encoding shared by the card shuffler and card dealer.
//   DECK_SIZE : number of cards held at consecutive RAM addresses
//   ADDR_W    : card RAM address width
//   DATA_W    : card value width
//   dealer_state_t : dealer FSM states; the encoding is fixed so the top
//                    FSM and debug tools can decode it directly.
// ---------------------------------------------------------------------------
package card_dealer_pkg;

    localparam int DECK_SIZE = 52;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        EMPTY   = 3'd4
    } dealer_state_t;

endpackage

// File: rtl/card_dealer_player.sv
// ---------------------------------------------------------------------------
// player_rotator
// Modulo-NUM_PLAYERS counter naming the player who receives the next card.
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   synchronous active-low reset
//   clear    in   synchronous clear back to player 0
//   advance  in   step to the next player in rotation
//   playerId out  current recipient (0 .. NUM_PLAYERS-1)
// ---------------------------------------------------------------------------
module player_rotator #(
    parameter int NUM_PLAYERS = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    output logic [1:0] playerId
);

    // Rotation counter: reset and clear both return to player 0, otherwise
    // step round-robin and wrap after the last player.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            playerId <= 2'd0;
        end else if (advance) begin
            if (playerId == 2'(NUM_PLAYERS - 1)) begin
                playerId <= 2'd0;
            end else begin
                playerId <= playerId + 2'd1;
            end
        end
    end

endmodule

// File: rtl/card_dealer.sv
// ---------------------------------------------------------------------------
// card_dealer
// Reads the shuffled deck out of the card RAM one address at a time and
// presents each card to the game logic with a valid/taken handshake, dealing
// round-robin to the players. Signals the top FSM when the deck is used up.
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   enable from top FSM; low acts as a soft reset
//   memData    in   RAM read data, valid the cycle after a memClock pulse
//   dealReq    in   request one card (level, only looked at in IDLE)
//   cardTaken  in   consumer accepted the presented card
//   memAddr    out  RAM address (BASE_ADDR + read pointer)
//   memClock   out  one-cycle RAM read strobe
//   card       out  presented card value
//   cardValid  out  card/playerId are valid
//   playerId   out  recipient of the presented card
//   cardsLeft  out  cards not yet taken
//   deckEmpty  out  every card has been taken
// ---------------------------------------------------------------------------
module card_dealer #(
    parameter int DECK_SIZE   = card_dealer_pkg::DECK_SIZE,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = card_dealer_pkg::ADDR_W,
    parameter int DATA_W      = card_dealer_pkg::DATA_W,
    parameter int NUM_PLAYERS = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] memData,
    input  logic              dealReq,
    input  logic              cardTaken,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memClock,
    output logic [DATA_W-1:0] card,
    output logic              cardValid,
    output logic [1:0]        playerId,
    output logic [ADDR_W-1:0] cardsLeft,
    output logic              deckEmpty
);

    import card_dealer_pkg::*;

    dealer_state_t     state;
    dealer_state_t     nextState;
    logic [ADDR_W-1:0] ptr;
    logic              takeNow;
    logic              lastCard;
    logic              softClear;

    // A take only counts while a card is actually on offer.
    assign takeNow   = (state == PRESENT) && cardTaken;
    // Widened by one bit so the compare cannot alias when ptr is near full.
    assign lastCard  = ({1'b0, ptr} + (ADDR_W + 1)'(1)) == (ADDR_W + 1)'(DECK_SIZE);
    assign softClear = !start;

    // Moore outputs decoded straight from the state register.
    assign memClock  = (state == READ);
    assign cardValid = (state == PRESENT);
    assign deckEmpty = (state == EMPTY);
    assign memAddr   = ADDR_W'(BASE_ADDR) + ptr;

    // Next-state logic. The soft reset from start is applied in the
    // sequential block, so here start can be assumed high.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (dealReq) nextState = READ;
            READ:    nextState = CAPTURE;
            CAPTURE: nextState = PRESENT;
            PRESENT: if (cardTaken) nextState = lastCard ? EMPTY : IDLE;
            EMPTY:   nextState = EMPTY;
            default: nextState = IDLE;
        endcase
    end

    // State, read pointer, card register and remaining-card count. A reset
    // or start drop abandons any card in flight without counting it.
    always_ff @(posedge clock) begin
        if (!reset_n || !start) begin
            state     <= IDLE;
            ptr       <= '0;
            cardsLeft <= ADDR_W'(DECK_SIZE);
            card      <= '0;
        end else begin
            state <= nextState;
            if (state == CAPTURE) begin
                card <= memData;
            end
            if (takeNow) begin
                ptr       <= ptr + ADDR_W'(1);
                cardsLeft <= cardsLeft - ADDR_W'(1);
            end
        end
    end

    player_rotator #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_rotator (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (softClear),
        .advance (takeNow),
        .playerId(playerId)
    );

endmodule

// File: tb/tb_card_dealer.sv
// ---------------------------------------------------------------------------
// tb_card_dealer
// Self-checking bench for card_dealer. Two instances share their inputs and
// run in lockstep: dutA deals to 2 players, dutB to 3. Each has its own RAM
// model. Expected values come from the deck contents and simple arithmetic
// on the number of cards dealt so far.
// ---------------------------------------------------------------------------
module tb_card_dealer;

    localparam int DECK = 52;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       dealReq;
    logic       cardTaken;

    logic [3:0] memDataA = '0;
    logic [3:0] memDataB = '0;
    logic [5:0] memAddrA, memAddrB;
    logic [5:0] cardsLeftA, cardsLeftB;
    logic       memClockA, memClockB;
    logic       cardValidA, cardValidB;
    logic       deckEmptyA, deckEmptyB;
    logic [3:0] cardA, cardB;
    logic [1:0] playerIdA, playerIdB;

    logic [3:0] ramA [64];
    logic [3:0] ramB [64];

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Card RAM models: read data appears the cycle after the strobe.
    always @(posedge clock) begin
        if (memClockA) memDataA <= ramA[memAddrA];
        if (memClockB) memDataB <= ramB[memAddrB];
    end

    card_dealer #(.NUM_PLAYERS(2)) dutA (
        .clock(clock), .reset_n(reset_n), .start(start), .memData(memDataA),
        .dealReq(dealReq), .cardTaken(cardTaken), .memAddr(memAddrA),
        .memClock(memClockA), .card(cardA), .cardValid(cardValidA),
        .playerId(playerIdA), .cardsLeft(cardsLeftA), .deckEmpty(deckEmptyA)
    );

    card_dealer #(.NUM_PLAYERS(3)) dutB (
        .clock(clock), .reset_n(reset_n), .start(start), .memData(memDataB),
        .dealReq(dealReq), .cardTaken(cardTaken), .memAddr(memAddrB),
        .memClock(memClockB), .card(cardB), .cardValid(cardValidB),
        .playerId(playerIdB), .cardsLeft(cardsLeftB), .deckEmpty(deckEmptyB)
    );

    // Hold reset for two edges, leave the bench at a negedge with reset off.
    task automatic applyReset;
        reset_n   = 1'b0;
        start     = 1'b1;
        dealReq   = 1'b0;
        cardTaken = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Pulse dealReq for one cycle and wait (bounded) for a presented card.
    // Reports the address seen with the read strobe, strobe count and the
    // number of edges from the request edge to cardValid.
    task automatic requestCard(output bit ok, output logic [5:0] readAddr,
                               output int strobes, output int latency);
        ok       = 1'b0;
        readAddr = '0;
        strobes  = 0;
        latency  = 0;
        dealReq  = 1'b1;
        @(negedge clock);
        dealReq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (memClockA) begin
                strobes++;
                readAddr = memAddrA;
            end
            if (cardValidA) begin
                ok      = 1'b1;
                latency = i + 1;
                break;
            end
            @(negedge clock);
        end
    endtask

    // Accept the presented card for exactly one edge.
    task automatic takeCard;
        cardTaken = 1'b1;
        @(negedge clock);
        cardTaken = 1'b0;
    endtask

    // Reset state then a quiet idle period with nothing requested.
    task automatic test_reset;
        applyReset();
        for (int i = 0; i < 11; i++) begin
            checks++;
            if ({cardValidA, memClockA, cardsLeftA, memAddrA, deckEmptyA, playerIdA} !==
                {1'b0, 1'b0, 6'd52, 6'd0, 1'b0, 2'd0}) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got valid=%b clk=%b left=%0d addr=%0d empty=%b pid=%0d required 0 0 52 0 0 0",
                         i, cardValidA, memClockA, cardsLeftA, memAddrA, deckEmptyA, playerIdA);
            end
            checks++;
            if ({cardValidB, cardsLeftB, cardB} !== {1'b0, 6'd52, 4'd0}) begin
                errors++;
                $display("[TB] FAIL reset_idle_b cycle %0d: got valid=%b left=%0d card=%0d required 0 52 0",
                         i, cardValidB, cardsLeftB, cardB);
            end
            @(negedge clock);
        end
    endtask

    // One card from address 0, held unaccepted for a while, then taken.
    task automatic test_single_deal;
        bit         ok;
        logic [5:0] addr;
        int         strobes;
        int         latency;
        ramA[0] = 4'd7;
        requestCard(ok, addr, strobes, latency);
        checks++;
        if (!ok || latency != 3) begin
            errors++;
            $display("[TB] FAIL single_latency: got ok=%0d negedges=%0d required ok=1 negedges=3", ok, latency);
        end
        checks++;
        if (strobes != 1 || addr !== 6'd0) begin
            errors++;
            $display("[TB] FAIL single_read: got strobes=%0d addr=%0d required 1 0", strobes, addr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({cardValidA, cardA, playerIdA, cardsLeftA, memClockA} !==
                {1'b1, 4'd7, 2'd0, 6'd52, 1'b0}) begin
                errors++;
                $display("[TB] FAIL single_hold cycle %0d: got valid=%b card=%0d pid=%0d left=%0d clk=%b required 1 7 0 52 0",
                         i, cardValidA, cardA, playerIdA, cardsLeftA, memClockA);
            end
            if (i < 5) @(negedge clock);
        end
        takeCard();
        checks++;
        if ({cardValidA, cardsLeftA, memAddrA, playerIdA} !== {1'b0, 6'd51, 6'd1, 2'd1}) begin
            errors++;
            $display("[TB] FAIL single_take: got valid=%b left=%0d addr=%0d pid=%0d required 0 51 1 1",
                     cardValidA, cardsLeftA, memAddrA, playerIdA);
        end
    endtask

    // cardTaken in IDLE and dealReq during PRESENT must have no effect.
    task automatic test_ignored_inputs;
        bit         ok;
        logic [5:0] addr;
        int         strobes;
        int         latency;
        for (int i = 0; i < 4; i++) begin
            cardTaken = (i % 2 == 0);
            @(negedge clock);
            checks++;
            if ({cardValidA, memClockA, cardsLeftA, memAddrA} !== {1'b0, 1'b0, 6'd51, 6'd1}) begin
                errors++;
                $display("[TB] FAIL idle_taken cycle %0d: got valid=%b clk=%b left=%0d addr=%0d required 0 0 51 1",
                         i, cardValidA, memClockA, cardsLeftA, memAddrA);
            end
        end
        cardTaken = 1'b0;
        requestCard(ok, addr, strobes, latency);
        checks++;
        if (!ok || addr !== 6'd1 || cardA !== ramA[1] || playerIdA !== 2'd1) begin
            errors++;
            $display("[TB] FAIL second_card: got ok=%0d addr=%0d card=%0d pid=%0d required 1 1 %0d 1",
                     ok, addr, cardA, playerIdA, ramA[1]);
        end
        for (int i = 0; i < 6; i++) begin
            dealReq = 1'($urandom % 2);
            @(negedge clock);
            checks++;
            if ({cardValidA, cardA, cardsLeftA, memClockA, playerIdA} !==
                {1'b1, ramA[1], 6'd51, 1'b0, 2'd1}) begin
                errors++;
                $display("[TB] FAIL present_dealreq cycle %0d: got valid=%b card=%0d left=%0d clk=%b pid=%0d required 1 %0d 51 0 1",
                         i, cardValidA, cardA, cardsLeftA, memClockA, playerIdA, ramA[1]);
            end
        end
        dealReq = 1'b0;
        takeCard();
        checks++;
        if ({cardsLeftA, memAddrA, playerIdA} !== {6'd50, 6'd2, 2'd0}) begin
            errors++;
            $display("[TB] FAIL ignored_take: got left=%0d addr=%0d pid=%0d required 50 2 0",
                     cardsLeftA, memAddrA, playerIdA);
        end
    endtask

    // Random deck and random handshake timing, then a reset while card 10
    // is on offer; the deal must restart from the top of the deck.
    task automatic test_mid_reset;
        bit         ok;
        logic [5:0] addr;
        int         strobes;
        int         latency;
        int         gap;
        applyReset();
        for (int i = 0; i < 64; i++) ramA[i] = 4'($urandom % 16);
        for (int n = 0; n <= 10; n++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                checks++;
                if ({cardValidA, memClockA, cardsLeftA} !== {1'b0, 1'b0, 6'(DECK - n)}) begin
                    errors++;
                    $display("[TB] FAIL rand_gap card %0d: got valid=%b clk=%b left=%0d required 0 0 %0d",
                             n, cardValidA, memClockA, cardsLeftA, DECK - n);
                end
            end
            requestCard(ok, addr, strobes, latency);
            checks++;
            if (!ok || addr !== 6'(n) || cardA !== ramA[n] || playerIdA !== 2'(n % 2) ||
                cardsLeftA !== 6'(DECK - n)) begin
                errors++;
                $display("[TB] FAIL rand_card %0d: got ok=%0d addr=%0d card=%0d pid=%0d left=%0d required 1 %0d %0d %0d %0d",
                         n, ok, addr, cardA, playerIdA, cardsLeftA, n, ramA[n], n % 2, DECK - n);
            end
            if (n == 10) break;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                checks++;
                if ({cardValidA, cardA} !== {1'b1, ramA[n]}) begin
                    errors++;
                    $display("[TB] FAIL rand_hold card %0d: got valid=%b card=%0d required 1 %0d",
                             n, cardValidA, cardA, ramA[n]);
                end
            end
            takeCard();
            checks++;
            if ({cardValidA, cardsLeftA, memAddrA} !== {1'b0, 6'(DECK - n - 1), 6'(n + 1)}) begin
                errors++;
                $display("[TB] FAIL rand_take card %0d: got valid=%b left=%0d addr=%0d required 0 %0d %0d",
                         n, cardValidA, cardsLeftA, memAddrA, DECK - n - 1, n + 1);
            end
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checks++;
        if ({cardValidA, cardsLeftA, playerIdA, memAddrA, deckEmptyA} !==
            {1'b0, 6'd52, 2'd0, 6'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got valid=%b left=%0d pid=%0d addr=%0d empty=%b required 0 52 0 0 0",
                     cardValidA, cardsLeftA, playerIdA, memAddrA, deckEmptyA);
        end
        requestCard(ok, addr, strobes, latency);
        checks++;
        if (!ok || addr !== 6'd0 || cardA !== ramA[0] || playerIdA !== 2'd0) begin
            errors++;
            $display("[TB] FAIL after_reset_deal: got ok=%0d addr=%0d card=%0d pid=%0d required 1 0 %0d 0",
                     ok, addr, cardA, playerIdA, ramA[0]);
        end
        takeCard();
    endtask

    // Whole deck with dealReq and cardTaken tied high.
    task automatic test_back_to_back;
        int n       = 0;
        int strobes = 0;
        int cyc     = 0;
        applyReset();
        for (int i = 0; i < 64; i++) ramA[i] = 4'(i % 16);
        dealReq   = 1'b1;
        cardTaken = 1'b1;
        while (!deckEmptyA && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (memClockA) begin
                checks++;
                if (memAddrA !== 6'(strobes)) begin
                    errors++;
                    $display("[TB] FAIL b2b_addr: got %0d required %0d", memAddrA, strobes);
                end
                strobes++;
            end
            if (cardValidA) begin
                checks++;
                if ({cardA, playerIdA, cardsLeftA} !== {4'(n % 16), 2'(n % 2), 6'(DECK - n)}) begin
                    errors++;
                    $display("[TB] FAIL b2b_card %0d: got card=%0d pid=%0d left=%0d required %0d %0d %0d",
                             n, cardA, playerIdA, cardsLeftA, n % 16, n % 2, DECK - n);
                end
                n++;
            end
        end
        checks++;
        if (!deckEmptyA || n != DECK || strobes != DECK || cardsLeftA !== 6'd0 ||
            cardValidA !== 1'b0 || memAddrA !== 6'd52) begin
            errors++;
            $display("[TB] FAIL b2b_end: got empty=%b cards=%0d strobes=%0d left=%0d valid=%b addr=%0d required 1 52 52 0 0 52",
                     deckEmptyA, n, strobes, cardsLeftA, cardValidA, memAddrA);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({deckEmptyA, memClockA, cardValidA, cardsLeftA} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
                errors++;
                $display("[TB] FAIL b2b_empty_hold cycle %0d: got empty=%b clk=%b valid=%b left=%0d required 1 0 0 0",
                         i, deckEmptyA, memClockA, cardValidA, cardsLeftA);
            end
        end
        dealReq   = 1'b0;
        cardTaken = 1'b0;
    endtask

    // Three-player rotation on dutB, then a one-cycle start drop mid-card.
    task automatic test_rotation_start_drop;
        bit         ok;
        logic [5:0] addr;
        int         strobes;
        int         latency;
        applyReset();
        for (int i = 0; i < 64; i++) ramB[i] = 4'($urandom % 16);
        for (int n = 0; n < 4; n++) begin
            requestCard(ok, addr, strobes, latency);
            checks++;
            if (!ok || cardValidB !== 1'b1 || playerIdB !== 2'(n % 3) || cardB !== ramB[n]) begin
                errors++;
                $display("[TB] FAIL rotation card %0d: got ok=%0d valid=%b pid=%0d card=%0d required 1 1 %0d %0d",
                         n, ok, cardValidB, playerIdB, cardB, n % 3, ramB[n]);
            end
            takeCard();
        end
        requestCard(ok, addr, strobes, latency);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        checks++;
        if ({cardValidB, cardsLeftB, playerIdB, memAddrB, deckEmptyB, memClockB, cardB} !==
            {1'b0, 6'd52, 2'd0, 6'd0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL start_drop: got valid=%b left=%0d pid=%0d addr=%0d empty=%b clk=%b card=%0d required 0 52 0 0 0 0 0",
                     cardValidB, cardsLeftB, playerIdB, memAddrB, deckEmptyB, memClockB, cardB);
        end
        requestCard(ok, addr, strobes, latency);
        checks++;
        if (!ok || memAddrB !== 6'd0 || playerIdB !== 2'd0 || cardB !== ramB[0]) begin
            errors++;
            $display("[TB] FAIL after_drop_deal: got ok=%0d addr=%0d pid=%0d card=%0d required 1 0 0 %0d",
                     ok, memAddrB, playerIdB, cardB, ramB[0]);
        end
        takeCard();
    endtask

    // Runs every scenario in turn and prints the summary.
    initial begin
        reset_n   = 1'b0;
        start     = 1'b1;
        dealReq   = 1'b0;
        cardTaken = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ramA[i] = 4'($urandom % 16);
            ramB[i] = 4'($urandom % 16);
        end
        test_reset();
        test_single_deal();
        test_ignored_inputs();
        test_mid_reset();
        test_back_to_back();
        test_rotation_start_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Read-side counterpart of the shuffler. After the top FSM reports the shuffle finished, it reads the shuffled deck out of the card RAM one address at a time.
- Each card is presented to the game logic with a valid/taken handshake.
- Cards are assigned round-robin to players.
- The deck-exhausted condition is signalled back to the top FSM.

Parameters:
- DECK_SIZE, 52, number of cards stored at consecutive RAM addresses.
- BASE_ADDR, 0, RAM address of the first card.
- ADDR_W, 6, RAM address width.
- DATA_W, 4, card value width.
- NUM_PLAYERS, 2, players dealt to in rotation (1..4).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  enable from top FSM; low forces the soft reset below.
- memData  in  DATA_W  RAM read data, valid the cycle after a memClock pulse.
- dealReq  in  1  request one card; level, sampled in IDLE only.
- cardTaken  in  1  consumer accepted the presented card.
- memAddr  out  ADDR_W  RAM address.
- memClock  out  1  one-cycle RAM clock strobe (read).
- card  out  DATA_W  presented card value.
- cardValid  out  1  card/playerId are valid.
- playerId  out  2  recipient of presented card.
- cardsLeft  out  ADDR_W  cards not yet taken.
- deckEmpty  out  1  all DECK_SIZE cards taken; to top FSM.

Behaviour:
- Reset (reset_n=0 at an edge), or start=0 at an edge:
  - state=IDLE, ptr=0, playerId=0, cardsLeft=DECK_SIZE, card=0.
  - cardValid=0, memClock=0, deckEmpty=0, memAddr=BASE_ADDR.
  - reset_n takes priority over start.
  - Mid-operation reset or start drop abandons any fetched or presented card; it is not counted.
- Outputs are Moore, decoded from state. card, playerId and cardsLeft are registers.
- memAddr = BASE_ADDR + ptr in every state, computed at ADDR_W bits (no wrap; BASE_ADDR+DECK_SIZE-1 must fit).
- State IDLE:
  - If dealReq=1 and start=1: go to READ.
  - Otherwise stay.
- State READ:
  - memClock=1 for exactly this cycle.
  - Always go to CAPTURE.
- State CAPTURE:
  - card <= memData at the exit edge.
  - Go to PRESENT.
- State PRESENT:
  - cardValid=1. Held until a cycle with cardTaken=1, with card and playerId stable.
  - On that edge: ptr++, cardsLeft--, playerId <= (playerId==NUM_PLAYERS-1) ? 0 : playerId+1.
  - Next state is EMPTY if ptr+1==DECK_SIZE, else IDLE.
- State EMPTY:
  - deckEmpty=1 and cardValid=0. Stay until reset or start=0.
  - dealReq is ignored.
- Latency: dealReq high in IDLE at edge k gives READ during k..k+1, CAPTURE during k+1..k+2, and cardValid=1 from edge k+2. Minimum 4 cycles per card with cardTaken tied high.
- Ignored inputs:
  - dealReq outside IDLE, including while PRESENT.
  - cardTaken outside PRESENT.
  - A held dealReq re-arms immediately on return to IDLE (back-to-back dealing).
- Invariant: cardsLeft == DECK_SIZE - ptr at every edge.
- memData values are passed through unchecked.
- The block never writes the RAM.

Decomposition:
- Shared package/header, also used by the shuffler:
  - DECK_SIZE, ADDR_W, DATA_W.
  - State encoding constants: IDLE=3'd0, READ=3'd1, CAPTURE=3'd2, PRESENT=3'd3, EMPTY=3'd4.
- Sub-module player_rotator: modulo-NUM_PLAYERS counter with advance enable and sync clear.
- Everything else is in one module with a single sequential block plus a combinational next-state/output block.

Test Plan:
- Reset and idle: hold reset_n=0 for 2 cycles, then release with start=1 and dealReq=0 for 10 cycles. Required: cardValid=0, memClock=0, cardsLeft=52, memAddr=0, deckEmpty=0 throughout.
- Single deal: RAM model holds addr0=4'd7. Pulse dealReq for 1 cycle. Required:
  - memClock=1 for exactly one cycle at memAddr=0.
  - cardValid rises 2 edges after the request edge, with card=7, playerId=0.
  - Hold cardTaken=0 for 5 cycles: outputs stay stable.
  - Assert cardTaken: cardValid=0, cardsLeft=51, memAddr=1.
- Full deck back-to-back: dealReq and cardTaken tied high, RAM addr i = i mod 16. Required:
  - 52 cards in address order, playerId alternating 0,1.
  - deckEmpty=1 after the 52nd take; cardsLeft=0; no memClock afterwards.
- Ignored inputs: cardTaken pulses while IDLE, and dealReq toggling during PRESENT. Required: no ptr or cardsLeft change; the presented card is unchanged.
- Mid-operation reset: drive reset_n=0 in the PRESENT cycle of card 10. Required next edge: cardValid=0, cardsLeft=52, playerId=0; the next deal reads addr 0.
- Start drop and rotation: NUM_PLAYERS=3, deal 4 cards. Required: playerId sequence 0,1,2,0. Then start=0 for 1 cycle, which must produce the same state as reset.
